// File: rtl/spi_frame_tx.sv
// spi_frame_tx: SPI responder that drives MISO with a fixed-length frame:
// GAP_BITS zero bits, the 8-bit HEADER, then PAYLOAD_BITS payload bits taken
// from a byte-wide valid/ready source. Everything is clocked by CLK_40; SPI_clk
// and chip_select are asynchronous and are synchronized internally.
//
// Optional feature (macro SPI_TX_CRC_EN): when defined, the payload is followed
// by 8 bits of CRC-8 (poly 0x07, init 0, no reflection, no final XOR) computed
// over the payload bits actually sent. When undefined, no CRC logic exists.
//
// Ports:
//   CLK_40       in   system clock
//   reset        in   synchronous, active-high reset
//   SPI_clk      in   SPI clock from master (async)
//   chip_select  in   active-low select from master (async)
//   tx_byte      in   payload byte, MSB sent first
//   tx_valid     in   tx_byte is valid
//   tx_ready     out  byte accepted this cycle when tx_valid is also high
//   MISO         out  registered serial data to master
//   frame_active out  high from frame start until done/abort
//   frame_done   out  1-cycle pulse after the last frame bit
//   frame_abort  out  1-cycle pulse when chip_select rises mid-frame
//   underrun     out  sticky: a payload byte was needed but none was held
module spi_frame_tx #(
  parameter logic [7:0]  HEADER       = 8'hFF,
  parameter int unsigned GAP_BITS     = 12,
  parameter int unsigned PAYLOAD_BITS = 64
) (
  input  logic       CLK_40,
  input  logic       reset,
  input  logic       SPI_clk,
  input  logic       chip_select,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       MISO,
  output logic       frame_active,
  output logic       frame_done,
  output logic       frame_abort,
  output logic       underrun
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BYTE_W = 13;
  localparam int unsigned NBYTES = (PAYLOAD_BITS + 7) / 8;
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_BITS - 1);
  localparam logic [CNT_W-1:0]  PAY_LAST = CNT_W'(PAYLOAD_BITS - 1);
  localparam logic [CNT_W-1:0]  BYTE_END = CNT_W'(7);
  localparam logic [BYTE_W-1:0] NBYTES_C = BYTE_W'(NBYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_HDR, S_PAY, S_CRC, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic spi_s1_q, spi_s2_q, spi_dly_q;
  logic cs_s1_q, cs_s2_q;
  logic spi_fall, cs_low, in_frame, accept;

  logic              miso_q, miso_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]        sh_q, sh_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic              underrun_q, underrun_d;
  logic [2:0]        hdr_idx;
`ifdef SPI_TX_CRC_EN
  logic [7:0]        crc_q, crc_d, crc_nxt;
`endif

  assign spi_fall = spi_s2_q & ~spi_dly_q;
  assign cs_low   = ~cs_s2_q;
  assign in_frame = (state_q == S_GAP) || (state_q == S_HDR) ||
                    (state_q == S_PAY) || (state_q == S_CRC);
  assign tx_ready = active_q & ~hold_vld_q & (byte_cnt_q < NBYTES_C);
  assign accept   = tx_valid & tx_ready;
  // Header bit to present after header bit bit_cnt_q has been shifted.
  assign hdr_idx  = 3'(3'd6 - bit_cnt_q[2:0]);

  assign MISO         = miso_q;
  assign frame_active = active_q;
  assign frame_done   = done_q;
  assign frame_abort  = abort_q;
  assign underrun     = underrun_q;

  // State register.
  always_ff @(posedge CLK_40) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; deselect mid-frame always wins.
  always_comb begin
    state_d = state_q;
    if (in_frame && !cs_low) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (cs_low) state_d = (GAP_BITS == 0) ? S_HDR : S_GAP;
        S_GAP:  if (spi_fall && bit_cnt_q == GAP_LAST) state_d = S_HDR;
        S_HDR:  if (spi_fall && bit_cnt_q == BYTE_END) state_d = S_PAY;
`ifdef SPI_TX_CRC_EN
        S_PAY:  if (spi_fall && bit_cnt_q == PAY_LAST) state_d = S_CRC;
`else
        S_PAY:  if (spi_fall && bit_cnt_q == PAY_LAST) state_d = S_DONE;
`endif
        S_CRC:  if (spi_fall && bit_cnt_q == BYTE_END) state_d = S_DONE;
        S_DONE: if (!cs_low) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    miso_d     = miso_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sh_d       = sh_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    active_d   = active_q;
    underrun_d = underrun_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
`ifdef SPI_TX_CRC_EN
    crc_d   = crc_q;
    crc_nxt = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ miso_q) ? 8'h07 : 8'h00);
`endif

    unique case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (cs_low) begin
          underrun_d = 1'b0;
          active_d   = 1'b1;
          byte_cnt_d = '0;
          hold_vld_d = 1'b0;
          miso_d     = (GAP_BITS == 0) ? HEADER[7] : 1'b0;
`ifdef SPI_TX_CRC_EN
          crc_d = 8'h00;
`endif
        end
      end
      S_GAP: if (spi_fall) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == GAP_LAST) miso_d = HEADER[7];
      end
      S_HDR: if (spi_fall) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == BYTE_END) begin
          // First payload byte: an empty hold sends zeros and flags underrun.
          sh_d       = hold_vld_q ? hold_q : 8'h00;
          miso_d     = hold_vld_q & hold_q[7];
          underrun_d = underrun_q | ~hold_vld_q;
          hold_vld_d = 1'b0;
        end else begin
          miso_d = HEADER[hdr_idx];
        end
      end
      S_PAY: if (spi_fall) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef SPI_TX_CRC_EN
        crc_d = crc_nxt;
`endif
        if (bit_cnt_q == PAY_LAST) begin
`ifdef SPI_TX_CRC_EN
          sh_d   = crc_nxt;
          miso_d = crc_nxt[7];
`else
          miso_d   = 1'b0;
          done_d   = 1'b1;
          active_d = 1'b0;
`endif
        end else if (bit_cnt_q[2:0] == 3'd7) begin
          sh_d       = hold_vld_q ? hold_q : 8'h00;
          miso_d     = hold_vld_q & hold_q[7];
          underrun_d = underrun_q | ~hold_vld_q;
          hold_vld_d = 1'b0;
        end else begin
          sh_d   = {sh_q[6:0], 1'b0};
          miso_d = sh_q[6];
        end
      end
      S_CRC: if (spi_fall) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == BYTE_END) begin
          miso_d   = 1'b0;
          done_d   = 1'b1;
          active_d = 1'b0;
        end else begin
          sh_d   = {sh_q[6:0], 1'b0};
          miso_d = sh_q[6];
        end
      end
      S_DONE: miso_d = 1'b0;
      default: miso_d = 1'b0;
    endcase

    if (in_frame && !cs_low) begin
      miso_d     = 1'b0;
      abort_d    = 1'b1;
      active_d   = 1'b0;
      hold_vld_d = 1'b0;
      underrun_d = underrun_q;
    end

    // Any load above has already consumed the old hold value.
    if (accept && !done_d && !abort_d) begin
      hold_d     = tx_byte;
      hold_vld_d = 1'b1;
      byte_cnt_d = byte_cnt_q + BYTE_W'(1);
    end

    if (state_d != state_q) bit_cnt_d = '0;
  end

  // Synchronizers and datapath registers; chip_select syncs reset to deselected.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      spi_s1_q   <= 1'b0;
      spi_s2_q   <= 1'b0;
      spi_dly_q  <= 1'b0;
      cs_s1_q    <= 1'b1;
      cs_s2_q    <= 1'b1;
      miso_q     <= 1'b0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      sh_q       <= 8'h00;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;
`ifdef SPI_TX_CRC_EN
      crc_q      <= 8'h00;
`endif
    end else begin
      spi_s1_q   <= SPI_clk;
      spi_s2_q   <= spi_s1_q;
      spi_dly_q  <= spi_s2_q;
      cs_s1_q    <= chip_select;
      cs_s2_q    <= cs_s1_q;
      miso_q     <= miso_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sh_q       <= sh_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      active_q   <= active_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      underrun_q <= underrun_d;
`ifdef SPI_TX_CRC_EN
      crc_q      <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// tb_spi_frame_tx: two responders (64-bit payload with 12-bit gap, and
// 12-bit payload with no gap) driven by an SPI master model; received bits
// are compared against an expected frame built from the frame rules.
module tb_spi_frame_tx;

  localparam logic [7:0] HDR = 8'hFF;
  localparam int GAP_A = 12;
  localparam int PAY_A = 64;
  localparam int GAP_B = 0;
  localparam int PAY_B = 12;
  localparam int HALF  = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk;
  logic       cs_n     [2];
  logic [7:0] tx_byte  [2];
  logic       tx_valid [2];
  logic       tx_ready [2];
  logic       miso     [2];
  logic       active   [2];
  logic       done     [2];
  logic       abort_s  [2];
  logic       urun     [2];

  int tests = 0;
  int fails = 0;
  int done_cnt [2] = '{0, 0};
  int abort_cnt[2] = '{0, 0};
  int acc      [2] = '{0, 0};
  int en       [2] = '{0, 0};
  bit pend     [2] = '{0, 0};
  logic [7:0] q[2][$];
  logic [7:0] fb[$];
  logic got[$];
  logic exp_bits[$];

  always #5 clk = ~clk;

  spi_frame_tx #(.HEADER(HDR), .GAP_BITS(GAP_A), .PAYLOAD_BITS(PAY_A)) u_dut_a (
    .CLK_40(clk), .reset(reset), .SPI_clk(sclk), .chip_select(cs_n[0]),
    .tx_byte(tx_byte[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .MISO(miso[0]), .frame_active(active[0]), .frame_done(done[0]),
    .frame_abort(abort_s[0]), .underrun(urun[0])
  );

  spi_frame_tx #(.HEADER(HDR), .GAP_BITS(GAP_B), .PAYLOAD_BITS(PAY_B)) u_dut_b (
    .CLK_40(clk), .reset(reset), .SPI_clk(sclk), .chip_select(cs_n[1]),
    .tx_byte(tx_byte[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .MISO(miso[1]), .frame_active(active[1]), .frame_done(done[1]),
    .frame_abort(abort_s[1]), .underrun(urun[1])
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte source with random valid stalls, plus pulse counters.
  initial begin
    for (int i = 0; i < 2; i++) begin
      tx_valid[i] = 1'b0;
      tx_byte[i]  = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (pend[i]) begin
          void'(q[i].pop_front());
          acc[i]++;
        end
        if (done[i] === 1'b1)    done_cnt[i]++;
        if (abort_s[i] === 1'b1) abort_cnt[i]++;
        if (en[i] != 0 && q[i].size() != 0 && $urandom_range(3) != 0) begin
          tx_valid[i] = 1'b1;
          tx_byte[i]  = q[i][0];
        end else begin
          tx_valid[i] = 1'b0;
          tx_byte[i]  = 8'($urandom);
        end
        pend[i] = (tx_valid[i] && tx_ready[i] === 1'b1);
      end
    end
  end

  task automatic clock_bits(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      repeat (HALF) @(negedge clk);
      got.push_back(miso[d]);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  // Expected frame: gap zeros, header MSB first, payload from the first
  // 'avail' bytes then zeros, optional CRC-8 over the payload bits.
  task automatic make_exp(input int gap, input int nb, input int avail);
    logic [7:0] hv;
    logic [7:0] cur;
    logic       b;
    logic [7:0] crc;
    hv  = HDR;
    crc = 8'h00;
    exp_bits.delete();
    for (int i = 0; i < gap; i++) exp_bits.push_back(1'b0);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(hv[i]);
    for (int p = 0; p < nb; p++) begin
      cur = (p / 8 < avail) ? fb[p / 8] : 8'h00;
      b   = cur[7 - (p % 8)];
      exp_bits.push_back(b);
      crc = (crc[7] ^ b) ? ({crc[6:0], 1'b0} ^ 8'h07) : {crc[6:0], 1'b0};
    end
`ifdef SPI_TX_CRC_EN
    for (int i = 7; i >= 0; i--) exp_bits.push_back(crc[i]);
`endif
  endtask

  task automatic chk_bits(input string tag);
    logic [127:0] gv;
    logic [127:0] ev;
    gv = '0;
    ev = '0;
    chk({tag, "_len"}, 128'(got.size()), 128'(exp_bits.size()));
    foreach (got[k])      gv = {gv[126:0], got[k]};
    foreach (exp_bits[k]) ev = {ev[126:0], exp_bits[k]};
    chk({tag, "_bits"}, gv, ev);
  endtask

  task automatic new_bytes(input int n);
    fb.delete();
    for (int k = 0; k < n; k++) fb.push_back(8'($urandom));
  endtask

  task automatic arm(input int d, input int avail, input int nby);
    @(posedge clk);
    q[d].delete();
    for (int k = 0; k < avail; k++) q[d].push_back(fb[k]);
    if (avail == nby) begin
      q[d].push_back(8'($urandom));
      q[d].push_back(8'($urandom));
    end
    acc[d]       = 0;
    done_cnt[d]  = 0;
    abort_cnt[d] = 0;
    en[d]        = 1;
    got.delete();
  endtask

  task automatic do_frame(input int d, input int avail, input string tag);
    int gap;
    int nb;
    int nby;
    gap = (d == 0) ? GAP_A : GAP_B;
    nb  = (d == 0) ? PAY_A : PAY_B;
    nby = (nb + 7) / 8;
    arm(d, avail, nby);
    make_exp(gap, nb, avail);
    @(negedge clk);
    cs_n[d] = 1'b0;
    repeat (6) @(negedge clk);
    chk({tag, "_start_active_urun"}, 128'({active[d], urun[d]}), 128'(2'b10));
    clock_bits(d, exp_bits.size());
    repeat (10) @(negedge clk);
    chk_bits(tag);
    chk({tag, "_done_cnt"}, 128'(done_cnt[d]), 128'(1));
    chk({tag, "_abort_cnt"}, 128'(abort_cnt[d]), 128'(0));
    chk({tag, "_accepted"}, 128'(acc[d]), 128'(avail));
    chk({tag, "_underrun"}, 128'(urun[d]), 128'(avail < nby));
    chk({tag, "_end_miso_active_ready"},
        128'({miso[d], active[d], tx_ready[d]}), 128'(3'b000));
    cs_n[d] = 1'b1;
    repeat (8) @(negedge clk);
    en[d] = 0;
  endtask

  initial begin
    #3000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    sclk  = 1'b0;
    cs_n[0] = 1'b1;
    cs_n[1] = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk("reset_outputs",
          128'({miso[i], tx_ready[i], active[i], done[i], abort_s[i], urun[i]}), 128'(0));
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_outputs_a",
        128'({miso[0], tx_ready[0], active[0], done[0], abort_s[0], urun[0]}), 128'(0));

    // Directed A5, 3C lead bytes.
    new_bytes(8);
    fb[0] = 8'hA5;
    fb[1] = 8'h3C;
    do_frame(0, 8, "basic");

    // Short payload, no gap: F0, AB -> 1111_0000_1010, two bytes only.
    fb.delete();
    fb.push_back(8'hF0);
    fb.push_back(8'hAB);
    do_frame(1, 2, "short12");

    // No bytes at all: zero payload, sticky underrun, cleared on next start.
    new_bytes(8);
    do_frame(0, 0, "underrun");
    new_bytes(8);
    do_frame(0, 8, "after_underrun");

    // Abort after 5 header bits.
    new_bytes(8);
    arm(0, 8, 8);
    @(negedge clk);
    cs_n[0] = 1'b0;
    repeat (6) @(negedge clk);
    clock_bits(0, GAP_A + 5);
    repeat (HALF) @(negedge clk);
    cs_n[0] = 1'b1;
    repeat (8) @(negedge clk);
    en[0] = 0;
    exp_bits.delete();
    for (int k = 0; k < GAP_A; k++) exp_bits.push_back(1'b0);
    for (int k = 0; k < 5; k++) exp_bits.push_back(1'b1);
    chk_bits("abort_prefix");
    chk("abort_cnt", 128'(abort_cnt[0]), 128'(1));
    chk("abort_no_done", 128'(done_cnt[0]), 128'(0));
    chk("abort_outputs", 128'({miso[0], active[0], tx_ready[0]}), 128'(0));
    new_bytes(8);
    do_frame(0, 8, "post_abort");

    // Reset in the middle of the payload.
    new_bytes(8);
    arm(0, 8, 8);
    @(negedge clk);
    cs_n[0] = 1'b0;
    repeat (6) @(negedge clk);
    clock_bits(0, GAP_A + 8 + 20);
    en[0] = 0;
    repeat (2) @(negedge clk);
    chk("mid_pay_active", 128'(active[0]), 128'(1));
    reset   = 1'b1;
    cs_n[0] = 1'b1;
    @(negedge clk);
    chk("reset_mid_outputs",
        128'({miso[0], tx_ready[0], active[0], done[0], abort_s[0], urun[0]}), 128'(0));
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("reset_no_pulses", 128'({done_cnt[0], abort_cnt[0]}), 128'(0));
    new_bytes(8);
    do_frame(0, 8, "post_reset");

    // Random frames on both responders, sometimes short of bytes.
    for (int r = 0; r < 6; r++) begin
      int d;
      int nby;
      int avail;
      d     = r % 2;
      nby   = (d == 0) ? (PAY_A + 7) / 8 : (PAY_B + 7) / 8;
      avail = ($urandom_range(2) == 0) ? int'($urandom_range(nby - 1)) : nby;
      new_bytes(nby);
      do_frame(d, avail, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
